// File: rtl/tomasulo_pkg.sv
// Shared types and helpers for the post-commit store buffer and its
// store-to-load forwarding lookup.
package tomasulo_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  localparam logic [1:0] MEM_SZ_BYTE = 2'b00;
  localparam logic [1:0] MEM_SZ_HALF = 2'b01;
  localparam logic [1:0] MEM_SZ_WORD = 2'b10;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [1:0]           size;
  } SB_Entry_t;

  // Bytes touched within the aligned word; bytes past the word boundary are cut off.
  function automatic logic [3:0] byte_mask(input logic [1:0] lsb, input logic [1:0] size);
    logic [3:0] m;
    case (size)
      MEM_SZ_BYTE: m = 4'b0001;
      MEM_SZ_HALF: m = 4'b0011;
      MEM_SZ_WORD: m = 4'b1111;
      default:     m = 4'b0000;
    endcase
    return m << lsb;
  endfunction

endpackage

// File: rtl/store_drain_scheduler_fwd.sv
// Per-load-port search of the store buffer, oldest to youngest so the
// youngest overlapping entry decides between forward and conflict.
module sb_fwd_lookup
  import tomasulo_pkg::*;
#(
  parameter int SB_DEPTH   = 8,
  parameter int ADDR_WIDTH = SB_ADDR_W,
  parameter int DATA_WIDTH = SB_DATA_W
) (
  input  SB_Entry_t                     entries [SB_DEPTH],
  input  logic [$clog2(SB_DEPTH)-1:0]   head,
  input  logic [$clog2(SB_DEPTH):0]     count,
  input  logic [ADDR_WIDTH-1:0]         ld_addr,
  input  logic [1:0]                    ld_size,
  output logic                          hit,
  output logic [DATA_WIDTH-1:0]         data,
  output logic                          conflict
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  logic [SB_ADDR_W-1:0] ld_a;
  logic [3:0]           ld_mask;
  logic [PW-1:0]        slot;
  SB_Entry_t            e;

  assign ld_a    = SB_ADDR_W'(ld_addr);
  assign ld_mask = byte_mask(ld_a[1:0], ld_size);

  always_comb begin
    hit      = 1'b0;
    conflict = 1'b0;
    data     = '0;
    slot     = '0;
    e        = '0;
    for (int a = 0; a < SB_DEPTH; a++) begin
      slot = head + PW'(a);
      e    = entries[slot];
      if ((CW'(a) < count) && (e.addr[SB_ADDR_W-1:2] == ld_a[SB_ADDR_W-1:2]) &&
          ((byte_mask(e.addr[1:0], e.size) & ld_mask) != 4'b0000)) begin
        if ((e.addr == ld_a) && (e.size == ld_size)) begin
          hit      = 1'b1;
          conflict = 1'b0;
          data     = DATA_WIDTH'(e.data);
        end else begin
          hit      = 1'b0;
          conflict = 1'b1;
          data     = '0;
        end
      end
    end
  end

endmodule

// File: rtl/store_drain_scheduler.sv
// Post-commit store buffer: compacts up to ISSUE_WIDTH retired stores per cycle
// and drains one per cycle to the data-memory write port. STORE_FWD_EN adds forwarding ports.
module store_drain_scheduler
  import tomasulo_pkg::*;
#(
  parameter int ISSUE_WIDTH = 3,
  parameter int SB_DEPTH    = 8,
  parameter int ADDR_WIDTH  = SB_ADDR_W,
  parameter int DATA_WIDTH  = SB_DATA_W
`ifdef STORE_FWD_EN
  , parameter int NUM_LD_PORTS = 2
`endif
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ISSUE_WIDTH-1:0]                 commit_valid,
  input  logic [ISSUE_WIDTH-1:0][ADDR_WIDTH-1:0] commit_addr,
  input  logic [ISSUE_WIDTH-1:0][DATA_WIDTH-1:0] commit_data,
  input  logic [ISSUE_WIDTH-1:0][1:0]            commit_size,
  output logic                                   commit_ready,
  input  logic                                   drain_hold,
  output logic                                   mem_write_en,
  output logic [ADDR_WIDTH-1:0]                  mem_write_addr,
  output logic [DATA_WIDTH-1:0]                  mem_write_data,
  output logic [1:0]                             mem_write_size,
  output logic [$clog2(SB_DEPTH):0]              sb_count,
  output logic                                   sb_empty,
  output logic                                   overflow_err
`ifdef STORE_FWD_EN
  , input  logic [NUM_LD_PORTS-1:0][ADDR_WIDTH-1:0] fwd_addr,
  input  logic [NUM_LD_PORTS-1:0][1:0]              fwd_size,
  output logic [NUM_LD_PORTS-1:0]                   fwd_hit,
  output logic [NUM_LD_PORTS-1:0][DATA_WIDTH-1:0]   fwd_data,
  output logic [NUM_LD_PORTS-1:0]                   fwd_conflict
`endif
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(SB_DEPTH);
  localparam logic [CW-1:0] ISSUE_C = CW'(ISSUE_WIDTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  SB_Entry_t                        sb_mem [SB_DEPTH];
  SB_Entry_t                        head_entry;
  logic [PW-1:0]                    head, tail;
  logic [CW-1:0]                    count, count_next, free_slots, n_acc;
  logic                             ready_q, err_q, pop, dropped;
  logic [ISSUE_WIDTH-1:0]           lane_acc;
  logic [ISSUE_WIDTH-1:0][PW-1:0]   lane_slot;

  assign free_slots = DEPTH_C - count;
  assign pop        = (count != '0) && !drain_hold && !rst;
  assign dropped    = |(commit_valid & ~lane_acc);
  assign count_next = count + n_acc - {{(CW-1){1'b0}}, pop};

  // Lane compaction: the k-th valid lane lands at tail+k and only if it fits.
  always_comb begin
    n_acc     = '0;
    lane_acc  = '0;
    lane_slot = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      lane_slot[i] = tail + n_acc[PW-1:0];
      if (commit_valid[i] && (n_acc < free_slots)) begin
        lane_acc[i] = 1'b1;
        n_acc       = n_acc + ONE_C;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      head    <= head + PW'(pop);
      tail    <= tail + n_acc[PW-1:0];
      count   <= count_next;
      ready_q <= (DEPTH_C - count_next) >= ISSUE_C;
      if (dropped) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (!rst && lane_acc[i]) begin
        sb_mem[lane_slot[i]] <= '{addr: SB_ADDR_W'(commit_addr[i]),
                                  data: SB_DATA_W'(commit_data[i]),
                                  size: commit_size[i]};
      end
    end
  end

  // Drain reads the pre-push head, so a commit never bypasses straight to memory.
  assign head_entry     = sb_mem[head];
  assign mem_write_en   = pop;
  assign mem_write_addr = pop ? ADDR_WIDTH'(head_entry.addr) : '0;
  assign mem_write_data = pop ? DATA_WIDTH'(head_entry.data) : '0;
  assign mem_write_size = pop ? head_entry.size : 2'b00;

  assign sb_count     = count;
  assign sb_empty     = (count == '0);
  assign commit_ready = ready_q;
  assign overflow_err = err_q;

`ifdef STORE_FWD_EN
  for (genvar p = 0; p < NUM_LD_PORTS; p++) begin : g_fwd
    sb_fwd_lookup #(
      .SB_DEPTH  (SB_DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lookup (
      .entries (sb_mem),
      .head    (head),
      .count   (count),
      .ld_addr (fwd_addr[p]),
      .ld_size (fwd_size[p]),
      .hit     (fwd_hit[p]),
      .data    (fwd_data[p]),
      .conflict(fwd_conflict[p])
    );
  end
`endif

endmodule

// File: tb/tb_store_drain_scheduler.sv
// Bench for store_drain_scheduler: directed scenarios then random traffic,
// checked against a queue-based model of the store buffer.
module tb_store_drain_scheduler;

  localparam int IW    = 3;
  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [IW-1:0]        commit_valid;
  logic [IW-1:0][31:0]  commit_addr;
  logic [IW-1:0][31:0]  commit_data;
  logic [IW-1:0][1:0]   commit_size;
  logic                 commit_ready;
  logic                 drain_hold;
  logic                 mem_write_en;
  logic [31:0]          mem_write_addr;
  logic [31:0]          mem_write_data;
  logic [1:0]           mem_write_size;
  logic [3:0]           sb_count;
  logic                 sb_empty;
  logic                 overflow_err;
`ifdef STORE_FWD_EN
  logic [1:0][31:0]     fwd_addr;
  logic [1:0][1:0]      fwd_size;
  logic [1:0]           fwd_hit;
  logic [1:0][31:0]     fwd_data;
  logic [1:0]           fwd_conflict;
`endif

  always #5 clk = ~clk;

  store_drain_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .commit_valid  (commit_valid),
    .commit_addr   (commit_addr),
    .commit_data   (commit_data),
    .commit_size   (commit_size),
    .commit_ready  (commit_ready),
    .drain_hold    (drain_hold),
    .mem_write_en  (mem_write_en),
    .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .mem_write_size(mem_write_size),
    .sb_count      (sb_count),
    .sb_empty      (sb_empty),
    .overflow_err  (overflow_err)
`ifdef STORE_FWD_EN
    , .fwd_addr    (fwd_addr),
    .fwd_size      (fwd_size),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data),
    .fwd_conflict  (fwd_conflict)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
  } ent_t;

  ent_t q[$];
  logic exp_err;
  logic exp_ready;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check outputs against the model, clock edge, advance the model.
  task automatic step(input logic [IW-1:0] v, input logic [IW-1:0][31:0] a,
                      input logic [IW-1:0][31:0] d, input logic [IW-1:0][1:0] s,
                      input logic h, input logic r);
    logic exp_en;
    int   free, acc;
    commit_valid = v;
    commit_addr  = a;
    commit_data  = d;
    commit_size  = s;
    drain_hold   = h;
    rst          = r;
    #1;
    exp_en = !r && !h && (q.size() != 0);
    chk("wr_en",   32'(mem_write_en), 32'(exp_en));
    chk("wr_addr", mem_write_addr, exp_en ? q[0].a : 32'h0);
    chk("wr_data", mem_write_data, exp_en ? q[0].d : 32'h0);
    chk("wr_size", 32'(mem_write_size), exp_en ? 32'(q[0].s) : 32'h0);
    chk("count",   32'(sb_count), q.size());
    chk("empty",   32'(sb_empty), 32'(q.size() == 0));
    chk("ready",   32'(commit_ready), 32'(exp_ready));
    chk("ovf",     32'(overflow_err), 32'(exp_err));
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_err = 1'b0;
    end else begin
      free = DEPTH - q.size();
      acc  = 0;
      if (exp_en) void'(q.pop_front());
      for (int i = 0; i < IW; i++) begin
        if (v[i]) begin
          if (acc < free) begin
            q.push_back('{a: a[i], d: d[i], s: s[i]});
            acc++;
          end else begin
            exp_err = 1'b1;
          end
        end
      end
    end
    exp_ready = (DEPTH - q.size()) >= IW;
    #1;
  endtask

  task automatic idle(input logic h);
    step('0, '0, '0, '0, h, 1'b0);
  endtask

  initial begin
    logic [IW-1:0]       rv;
    logic [IW-1:0][31:0] ra, rd;
    logic [IW-1:0][1:0]  rs;
    logic                rh, rr;

    rst          = 1'b1;
    commit_valid = '0;
    commit_addr  = '0;
    commit_data  = '0;
    commit_size  = '0;
    drain_hold   = 1'b0;
`ifdef STORE_FWD_EN
    fwd_addr = '0;
    fwd_size = '0;
`endif
    @(posedge clk);
    #1;
    exp_err   = 1'b0;
    exp_ready = 1'b1;

    // Three lanes at once, drained in lane order one per cycle
    step(3'b111, {32'h18, 32'h14, 32'h10}, {32'hC, 32'hB, 32'hA}, {2'b10, 2'b10, 2'b10}, 1'b0, 1'b0);
    repeat (4) idle(1'b0);

    // Hold fills to 6 and drops commit_ready, release drains in order
    step(3'b111, {32'h108, 32'h104, 32'h100}, {32'h3, 32'h2, 32'h1}, {2'b10, 2'b01, 2'b00}, 1'b1, 1'b0);
    step(3'b111, {32'h114, 32'h110, 32'h10C}, {32'h6, 32'h5, 32'h4}, {2'b00, 2'b10, 2'b10}, 1'b1, 1'b0);
    idle(1'b1);
    repeat (7) idle(1'b0);

    // Sparse lanes while the head is draining
    step(3'b001, {32'h0, 32'h0, 32'h1C}, {32'h0, 32'h0, 32'h77}, {2'b00, 2'b00, 2'b10}, 1'b0, 1'b0);
    step(3'b101, {32'h28, 32'h24, 32'h20}, {32'h99, 32'h55, 32'h88}, {2'b10, 2'b10, 2'b10}, 1'b0, 1'b0);
    repeat (3) idle(1'b0);

    // Forced commit at count 7: only lane0 fits, sticky overflow
    step(3'b111, {32'h208, 32'h204, 32'h200}, {32'h21, 32'h20, 32'h1F}, {2'b10, 2'b10, 2'b10}, 1'b1, 1'b0);
    step(3'b111, {32'h214, 32'h210, 32'h20C}, {32'h24, 32'h23, 32'h22}, {2'b10, 2'b10, 2'b10}, 1'b1, 1'b0);
    step(3'b001, {32'h0, 32'h0, 32'h218}, {32'h0, 32'h0, 32'h25}, {2'b00, 2'b00, 2'b10}, 1'b1, 1'b0);
    step(3'b111, {32'h224, 32'h220, 32'h21C}, {32'h28, 32'h27, 32'h26}, {2'b10, 2'b10, 2'b10}, 1'b1, 1'b0);
    idle(1'b1);
    repeat (3) idle(1'b0);

    // Reset with 5 pending discards them
    step('0, '0, '0, '0, 1'b0, 1'b1);
    repeat (3) idle(1'b0);

`ifdef STORE_FWD_EN
    step(3'b001, {32'h0, 32'h0, 32'h40}, {32'h0, 32'h0, 32'hDEADBEEF}, {2'b00, 2'b00, 2'b10}, 1'b1, 1'b0);
    fwd_addr[0] = 32'h40;
    fwd_size[0] = 2'b10;
    fwd_addr[1] = 32'h41;
    fwd_size[1] = 2'b00;
    #1;
    chk("fwd_hit",  32'(fwd_hit[0]), 32'h1);
    chk("fwd_data", fwd_data[0], 32'hDEADBEEF);
    chk("fwd_cfl0", 32'(fwd_conflict[0]), 32'h0);
    chk("fwd_cfl1", 32'(fwd_conflict[1]), 32'h1);
    chk("fwd_hit1", 32'(fwd_hit[1]), 32'h0);
    step('0, '0, '0, '0, 1'b0, 1'b1);
`endif

    // Random traffic, mostly honouring commit_ready
    for (int n = 0; n < 400; n++) begin
      rv = IW'($urandom);
      if (!commit_ready && ($urandom_range(7) != 0)) rv = '0;
      for (int i = 0; i < IW; i++) begin
        ra[i] = $urandom;
        rd[i] = $urandom;
        rs[i] = 2'($urandom_range(2));
      end
      rh = ($urandom_range(3) == 0);
      rr = ($urandom_range(99) == 0);
      step(rv, ra, rd, rs, rh, rr);
    end
    repeat (DEPTH + 1) idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
